ddr3_traffic_gen: RTL and testbench

- User-side initiator for the DDR3 memory controller application interface.
- On a start request it writes NUM_BURSTS bursts of a known pattern from BASE_ADDR, reads them back in order, and compares each beat.
- Status outputs (busy/done/pass/error count/last-read nibble) feed the board display/LED logic, alongside the start/display button front end.

---
 rtl/ddr3_traffic_gen.sv | 161 ++++++++++++++++
 tb/tb_ddr3_traffic_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_traffic_gen.sv
// Write/read-back traffic generator for the DDR3 controller application interface.
// Define DDR3_TG_PRBS_EN to replace the incrementing pattern with a 32-bit Galois LFSR.
module ddr3_traffic_gen #(
  parameter int                    ADDR_WIDTH   = 28,
  parameter int                    DATA_WIDTH   = 128,
  parameter int                    NUM_BURSTS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter logic [31:0]           PATTERN_SEED = 32'hA5A5_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    init_calib_complete,
  output logic [2:0]              app_cmd,
  output logic                    app_cmd_en,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic                    app_cmd_rdy,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]   app_rd_data,
  input  logic                    app_rd_data_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_cnt,
  output logic [3:0]              show_data,
  output logic [2:0]              state_dbg
);

  // Handshakes: a command transfers on a cycle where app_cmd_en && app_cmd_rdy,
  // a write beat where app_wdf_wren && app_wdf_rdy; offered values stay put until then.
  localparam int                IDX_W    = 17;
  localparam int                REP      = DATA_WIDTH / 32;
  localparam logic [IDX_W-1:0]  N        = IDX_W'(NUM_BURSTS);
  localparam logic [IDX_W-1:0]  LAST     = N - 17'd1;
  localparam logic [2:0]        CMD_WR   = 3'b000;
  localparam logic [2:0]        CMD_RD   = 3'b001;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;
  state_t state, state_nxt;

  logic             start_d;
  logic [IDX_W-1:0] wr_idx, wrd_idx, rd_idx, chk_idx;
  logic             pass_q;
  logic [31:0]      wr_word, chk_word;
  logic             accept, cmd_hs, wdf_hs, rd_beat, beat_bad;

  function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + ADDR_WIDTH'({idx, 3'b000});
  endfunction

  assign accept   = (state == IDLE) && start && !start_d && init_calib_complete;
  assign cmd_hs   = app_cmd_en && app_cmd_rdy;
  assign wdf_hs   = app_wdf_wren && app_wdf_rdy;
  assign rd_beat  = app_rd_data_valid && (state == READ || state == DRAIN) && (chk_idx < N);
  assign beat_bad = (app_rd_data != {REP{chk_word}});

  always_comb begin
    state_nxt    = state;
    app_cmd      = CMD_WR;
    app_cmd_en   = 1'b0;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    app_wdf_data = '0;
    case (state)
      IDLE: if (accept) state_nxt = WRITE;
      WRITE: begin
        if (wr_idx < N) begin
          app_cmd_en = 1'b1;
          app_addr   = burst_addr(wr_idx);
        end
        if (wrd_idx < N) begin
          app_wdf_wren = 1'b1;
          app_wdf_data = {REP{wr_word}};
        end
        if (wr_idx == N && wrd_idx == N) state_nxt = READ;
      end
      READ: begin
        app_cmd    = CMD_RD;
        app_cmd_en = 1'b1;
        app_addr   = burst_addr(rd_idx);
        if (app_cmd_rdy && rd_idx == LAST) state_nxt = DRAIN;
      end
      DRAIN: if (chk_idx == N || (rd_beat && chk_idx == LAST)) state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start_d   <= 1'b0;
      wr_idx    <= '0;
      wrd_idx   <= '0;
      rd_idx    <= '0;
      chk_idx   <= '0;
      err_cnt   <= '0;
      pass_q    <= 1'b0;
      show_data <= '0;
    end else begin
      state   <= state_nxt;
      start_d <= start;
      if (accept) begin
        wr_idx  <= '0;
        wrd_idx <= '0;
        rd_idx  <= '0;
        chk_idx <= '0;
        err_cnt <= '0;
      end
      if (state == WRITE && cmd_hs) wr_idx <= wr_idx + 17'd1;
      if (wdf_hs) wrd_idx <= wrd_idx + 17'd1;
      if (state == READ && cmd_hs) rd_idx <= rd_idx + 17'd1;
      if (rd_beat) begin
        chk_idx   <= chk_idx + 17'd1;
        show_data <= app_rd_data[3:0];
        if (beat_bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
      if (state == FINISH) pass_q <= (err_cnt == 16'd0);
    end
  end

`ifdef DDR3_TG_PRBS_EN
  logic [31:0] wr_lfsr, chk_lfsr;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_lfsr  <= PATTERN_SEED;
      chk_lfsr <= PATTERN_SEED;
    end else if (accept) begin
      wr_lfsr  <= PATTERN_SEED;
      chk_lfsr <= PATTERN_SEED;
    end else begin
      if (wdf_hs)  wr_lfsr  <= lfsr_next(wr_lfsr);
      if (rd_beat) chk_lfsr <= lfsr_next(chk_lfsr);
    end
  end

  assign wr_word  = wr_lfsr;
  assign chk_word = chk_lfsr;
`else
  assign wr_word  = PATTERN_SEED + 32'(wrd_idx);
  assign chk_word = PATTERN_SEED + 32'(chk_idx);
`endif

  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;
  assign busy         = (state == WRITE) || (state == READ) || (state == DRAIN);
  assign done         = (state == FINISH);
  assign pass         = done ? (err_cnt == 16'd0) : pass_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// Bench for ddr3_traffic_gen: loopback controller model with random throttling,
// a pattern reference model, expected-address/data queues and a final report.
module tb_ddr3_traffic_gen;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int N  = 16;
  localparam logic [AW-1:0] BASE = '0;
`ifdef DDR3_TG_PRBS_EN
  localparam logic [31:0] SEED = 32'h0000_0001;
`else
  localparam logic [31:0] SEED = 32'hA5A5_0000;
`endif

  logic          clk, rst, start, init_calib_complete;
  logic [2:0]    app_cmd;
  logic          app_cmd_en, app_cmd_rdy;
  logic [AW-1:0] app_addr;
  logic [DW-1:0] app_wdf_data, app_rd_data;
  logic          app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;
  logic [DW/8-1:0] app_wdf_mask;
  logic          busy, done, pass;
  logic [15:0]   err_cnt;
  logic [3:0]    show_data;
  logic [2:0]    state_dbg;

  ddr3_traffic_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BURSTS(N), .BASE_ADDR(BASE), .PATTERN_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .init_calib_complete(init_calib_complete),
    .app_cmd(app_cmd), .app_cmd_en(app_cmd_en), .app_addr(app_addr), .app_cmd_rdy(app_cmd_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .show_data(show_data), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_word(input int i);
    logic [31:0] s;
`ifdef DDR3_TG_PRBS_EN
    s = SEED;
    for (int k = 0; k < i; k++) s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
`else
    s = SEED + 32'(i);
`endif
    return s;
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_wa_q[$];
  logic [AW-1:0] exp_ra_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_expect();
    exp_q.delete(); exp_wa_q.delete(); exp_ra_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_wa_q.push_back(BASE + AW'(8 * i));
      exp_ra_q.push_back(BASE + AW'(8 * i));
      exp_q.push_back({4{ref_word(i)}});
    end
  endtask

  // ---------------- controller / memory model ----------------
  logic          throttle = 1'b0;
  logic [N-1:0]  cmask = '0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            wcmd_cnt = 0, wdat_cnt = 0, rcmd_cnt = 0;
  logic [AW-1:0] wlog_addr [N];
  logic [DW-1:0] wlog_data [N];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] wcmd_q[$];
  logic [DW-1:0] wdat_q[$];
  logic [DW-1:0] rd_dat_q[$];
  int            rd_due_q[$];

  task automatic flush_model();
    wcmd_q.delete(); wdat_q.delete(); rd_dat_q.delete(); rd_due_q.delete();
    exp_q.delete(); exp_wa_q.delete(); exp_ra_q.delete();
  endtask

  initial begin
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, d;
    int bidx;
    app_cmd_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data = '0;   app_rd_data_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_due_q.size() != 0 && rd_due_q[0] <= cyc) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = rd_dat_q.pop_front();
        void'(rd_due_q.pop_front());
      end else begin
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
      end
      app_cmd_rdy = throttle ? ($urandom_range(0, 1) == 1) : 1'b1;
      app_wdf_rdy = throttle ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (done) done_cnt++;
      if (app_cmd_en && app_cmd_rdy) begin
        if (app_cmd == 3'b000) begin
          if (exp_wa_q.size() != 0) ea = exp_wa_q.pop_front(); else ea = 'x;
          check("wr_addr", 128'(app_addr), 128'(ea));
          if (wcmd_cnt < N) wlog_addr[wcmd_cnt] = app_addr;
          wcmd_q.push_back(app_addr);
          wcmd_cnt++;
        end else begin
          if (exp_ra_q.size() != 0) ea = exp_ra_q.pop_front(); else ea = 'x;
          check("rd_addr", 128'(app_addr), 128'(ea));
          bidx = int'((app_addr - BASE) >> 3);
          d = mem[app_addr];
          if (bidx >= 0 && bidx < N && cmask[bidx]) d[0] = ~d[0];
          rd_dat_q.push_back(d);
          rd_due_q.push_back(cyc + 4);
          rcmd_cnt++;
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        if (exp_q.size() != 0) ed = exp_q.pop_front(); else ed = 'x;
        check("wr_data", app_wdf_data, ed);
        check("wdf_end", 128'(app_wdf_end), 128'(1));
        check("wdf_mask", 128'(app_wdf_mask), 128'(0));
        if (wdat_cnt < N) wlog_data[wdat_cnt] = app_wdf_data;
        wdat_q.push_back(app_wdf_data);
        wdat_cnt++;
      end
      while (wcmd_q.size() != 0 && wdat_q.size() != 0) mem[wcmd_q.pop_front()] = wdat_q.pop_front();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_pass(input string tag, input logic [N-1:0] mask, input logic thr,
                          input logic mid_start);
    int base_done, exp_e;
    logic finished, sent;
    logic [31:0] lw;
    cmask = mask; throttle = thr;
    load_expect();
    wcmd_cnt = 0; wdat_cnt = 0; rcmd_cnt = 0;
    base_done = done_cnt; finished = 1'b0; sent = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mid_start && !sent && err_cnt != 16'd0) begin
        start = 1'b1;
        sent = 1'b1;
      end
      if (done) finished = 1'b1;
    end
    start = 1'b0;
    check({tag, "/done_seen"}, 128'(finished), 128'(1));
    repeat (3) @(negedge clk);
    exp_e = $countones(mask);
    lw = ref_word(N - 1);
    check({tag, "/done_pulses"}, 128'(done_cnt - base_done), 128'(1));
    check({tag, "/pass"}, 128'(pass), 128'(exp_e == 0));
    check({tag, "/err_cnt"}, 128'(err_cnt), 128'(exp_e));
    check({tag, "/show_data"}, 128'(show_data), 128'({lw[3:1], lw[0] ^ mask[N-1]}));
    check({tag, "/wr_cmds"}, 128'(wcmd_cnt), 128'(N));
    check({tag, "/wr_beats"}, 128'(wdat_cnt), 128'(N));
    check({tag, "/rd_cmds"}, 128'(rcmd_cnt), 128'(N));
    check({tag, "/busy_after"}, 128'(busy), 128'(0));
    if (mid_start) check({tag, "/mid_start_sent"}, 128'(sent), 128'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] w;
    rst = 1'b1; start = 1'b0; init_calib_complete = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_pass", 128'(pass), 128'(0));
    check("rst_err", 128'(err_cnt), 128'(0));
    check("rst_show", 128'(show_data), 128'(0));
    check("rst_cmd_en", 128'(app_cmd_en), 128'(0));
    check("rst_wren", 128'(app_wdf_wren), 128'(0));
    check("rst_cmd", 128'(app_cmd), 128'(0));
    check("rst_addr", 128'(app_addr), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // start while calibration incomplete is dropped
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("nocal_busy", 128'(busy), 128'(0));
    check("nocal_cmd_en", 128'(app_cmd_en), 128'(0));
    check("nocal_done", 128'(done_cnt), 128'(0));
    init_calib_complete = 1'b1;
    @(negedge clk);

    run_pass("ideal", '0, 1'b0, 1'b0);
    check("ideal/addr0", 128'(wlog_addr[0]), 128'(0));
    check("ideal/addr15", 128'(wlog_addr[15]), 128'(120));
`ifdef DDR3_TG_PRBS_EN
    check("ideal/beat1", wlog_data[1], {4{32'h8020_0003}});
`else
    check("ideal/beat5", wlog_data[5], {4{32'hA5A5_0005}});
`endif

    run_pass("throttle", '0, 1'b1, 1'b0);
    run_pass("corrupt39", 16'h0208, 1'b1, 1'b1);

    // synchronous reset in the middle of the write phase
    throttle = 1'b0; cmask = '0;
    load_expect();
    wcmd_cnt = 0; wdat_cnt = 0; rcmd_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && wdat_cnt < 7; c++) @(negedge clk);
    check("rst_mid/reached7", 128'(wdat_cnt >= 7), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid/busy", 128'(busy), 128'(0));
    check("rst_mid/cmd_en", 128'(app_cmd_en), 128'(0));
    check("rst_mid/wren", 128'(app_wdf_wren), 128'(0));
    check("rst_mid/err", 128'(err_cnt), 128'(0));
    check("rst_mid/show", 128'(show_data), 128'(0));
    check("rst_mid/pass", 128'(pass), 128'(0));
    flush_model();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_pass("post_rst", '0, 1'b0, 1'b0);
    run_pass("corrupt7", 16'h0080, 1'b0, 1'b0);
    run_pass("random", N'($urandom()), 1'b1, 1'b0);

    w = ref_word(0);
    check("seed_word", 128'(w), 128'(SEED));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
